if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between the instruction memory port and the ID stage. Decouples fetch from decode back-pressure, keeps one memory request in flight, and applies static branch prediction at fetch. It discards stale responses after a branch or flush redirect. It replaces the single-register fetch stage and sits between the icache read port and the IF/ID handshake.

---
 rtl/if_prefetch_stage_pkg.sv | 16 +
 rtl/if_prefetch_stage_if.sv | 38 +++
 rtl/if_prefetch_stage_fifo.sv | 49 ++++
 rtl/if_prefetch_stage.sv | 126 ++++++++++++
 tb/tb_if_prefetch_stage.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_stage_pkg.sv
// Shared types for the instruction-fetch prefetch stage.
package if_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        br_pred;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL
    } fetch_state_e;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Fetch-stage bus: icache read port plus the IF/ID handshake.
interface if_prefetch_stage_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        valid_o;
    logic        ack_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        br_pred_o;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_valid_i,
        input  mem_data_i,
        output valid_o,
        input  ack_i,
        output instr_o,
        output pc_o,
        output br_pred_o
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_valid_i,
        output mem_data_i,
        input  valid_o,
        output ack_i,
        input  instr_o,
        input  pc_o,
        input  br_pred_o
    );

endinterface

// File: rtl/if_prefetch_stage_fifo.sv
// Circular prefetch queue; clear wins over push/pop.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_q  <= '0;
            wr_q  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= din;
                wr_q      <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_q];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction fetch with prefetch queue, one request in flight,
// static branch prediction and stale-response killing.
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          BP_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   branch_i,
    input  logic [31:0]            pc_i,
    input  logic                   halt_i,
    output logic [31:0]            bp_instr_o,
    output logic [31:0]            bp_pc_o,
    input  logic                   bp_taken_i,
    input  logic [31:0]            bp_target_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [31:0]            dbg_pc_o,
    if_prefetch_stage_if.master    bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [31:0]   kill_q;
    logic [31:0]   kill_d;
    logic [31:0]   mem_addr;
    logic          redirect;
    logic          taken;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_post;
    fetch_entry_t  din;
    fetch_entry_t  head;

    assign redirect = flush_i | branch_i;
    assign taken    = BP_EN & bp_taken_i;
    assign push     = (state_q == REQ) && bus.mem_valid_i && !redirect;
    assign pop      = bus.ack_i && (count != '0) && !redirect;
    assign cnt_post = count + CW'(push) - CW'(pop);

    assign din = '{instr: bus.mem_data_i, pc: pc_q, br_pred: taken};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        if (redirect) begin
            pc_d    = pc_i;
            state_d = IDLE;
            // the in-flight request cannot be aborted, so its response is dropped
            if ((state_q != IDLE) && !bus.mem_valid_i) begin
                state_d = KILL;
            end
            if ((state_q == REQ) && !bus.mem_valid_i) begin
                kill_d = pc_q;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!halt_i && (count < CW'(DEPTH))) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_valid_i) begin
                        pc_d    = taken ? bp_target_i : pc_q + 32'd4;
                        state_d = (!halt_i && (cnt_post < CW'(DEPTH))) ? REQ : IDLE;
                    end
                end
                KILL: begin
                    if (bus.mem_valid_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk    (clk),
        .rstn_i (rstn_i),
        .clear  (redirect),
        .push   (push),
        .pop    (pop),
        .din    (din),
        .head   (head),
        .count  (count)
    );

    assign mem_addr       = (state_q == KILL) ? kill_q : pc_q;
    assign bus.mem_req_o  = (state_q != IDLE);
    assign bus.mem_addr_o = mem_addr;
    assign bus.valid_o    = (count != '0);
    assign bus.instr_o    = head.instr;
    assign bus.pc_o       = head.pc;
    assign bus.br_pred_o  = head.br_pred;
    assign bp_instr_o     = bus.mem_data_i;
    assign bp_pc_o        = mem_addr;
    assign count_o        = count;
    assign dbg_pc_o       = pc_q;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage (BP_EN=1 and BP_EN=0 instances).
module tb_if_prefetch_stage;
  import if_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic ack, halt, flush, branch, bp_on;
  logic [31:0] pc_in, bp_match, bp_target;
  logic [31:0] bp_instr0, bp_pc0, dbg_pc0;
  logic [31:0] bp_instr1, bp_pc1, dbg_pc1;
  logic bp_taken0;
  logic [2:0] count0, count1;
  int lat;
  int wcnt;
  int n_chk = 0;
  int n_fail = 0;
  int n;

  if_prefetch_stage_if fe0();
  if_prefetch_stage_if fe1();

  if_prefetch_stage #(
    .DEPTH(4), .RESET_PC(32'h0), .BP_EN(1'b1)
  ) dut0 (
    .clk(clk), .rstn_i(rstn),
    .flush_i(flush), .branch_i(branch),
    .pc_i(pc_in), .halt_i(halt),
    .bp_instr_o(bp_instr0), .bp_pc_o(bp_pc0),
    .bp_taken_i(bp_taken0), .bp_target_i(bp_target),
    .count_o(count0), .dbg_pc_o(dbg_pc0),
    .bus(fe0)
  );

  if_prefetch_stage #(
    .DEPTH(4), .RESET_PC(32'h0), .BP_EN(1'b0)
  ) dut1 (
    .clk(clk), .rstn_i(rstn),
    .flush_i(1'b0), .branch_i(1'b0),
    .pc_i(32'h0), .halt_i(1'b0),
    .bp_instr_o(bp_instr1), .bp_pc_o(bp_pc1),
    .bp_taken_i(1'b1), .bp_target_i(32'h40),
    .count_o(count1), .dbg_pc_o(dbg_pc1),
    .bus(fe1)
  );

  assign bp_taken0 = bp_on && (bp_pc0 == bp_match);
  assign fe0.ack_i = ack;
  assign fe1.ack_i = 1'b1;

  // memory: response after lat wait cycles, data tagged with address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wcnt <= 0;
    else if (fe0.mem_req_o && !fe0.mem_valid_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always_comb begin
    fe0.mem_valid_i = fe0.mem_req_o && (wcnt >= lat);
    fe0.mem_data_i  = {16'hC0DE, fe0.mem_addr_o[15:0]};
    fe1.mem_valid_i = fe1.mem_req_o;
    fe1.mem_data_i  = {16'hC0DE, fe1.mem_addr_o[15:0]};
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    ack = 1'b1; halt = 1'b0; flush = 1'b0; branch = 1'b0;
    pc_in = 32'h0; lat = 0; bp_on = 1'b0;
    bp_match = 32'h0; bp_target = 32'h40;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin
    // A: reset values, first-fetch latency, streaming
    rstn = 1'b0;
    ack = 1'b1; halt = 1'b0; flush = 1'b0; branch = 1'b0;
    pc_in = 32'h0; lat = 0; bp_on = 1'b0;
    bp_match = 32'h0; bp_target = 32'h40;
    repeat (2) tick();
    check("rst_valid", 32'(fe0.valid_o), 32'd0);
    check("rst_req", 32'(fe0.mem_req_o), 32'd0);
    check("rst_addr", fe0.mem_addr_o, 32'h0);
    check("rst_dbg", dbg_pc0, 32'h0);
    check("rst_count", 32'(count0), 32'd0);
    check("rst_instr", fe0.instr_o, 32'h0);
    check("rst_pc", fe0.pc_o, 32'h0);
    check("rst_pred", 32'(fe0.br_pred_o), 32'd0);
    rstn = 1'b1;
    tick();
    check("a_req1", 32'(fe0.mem_req_o), 32'd1);
    check("a_valid1", 32'(fe0.valid_o), 32'd0);
    tick();
    check("a_valid2", 32'(fe0.valid_o), 32'd1);
    check("a_pc0", fe0.pc_o, 32'h0);
    check("a_instr0", fe0.instr_o, 32'hC0DE0000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("a_stream_pc", fe0.pc_o, 32'(4 * k));
      check("a_stream_cnt", 32'(count0), 32'd1);
    end

    // B: back-pressure fills the queue, one ack frees one slot
    do_reset();
    ack = 1'b0;
    repeat (5) tick();
    check("b_full", 32'(count0), 32'd4);
    check("b_req_off", 32'(fe0.mem_req_o), 32'd0);
    check("b_head", fe0.pc_o, 32'h0);
    repeat (3) tick();
    check("b_still_off", 32'(fe0.mem_req_o), 32'd0);
    check("b_still_full", 32'(count0), 32'd4);
    check("b_dbg", dbg_pc0, 32'h10);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("b_cnt3", 32'(count0), 32'd3);
    check("b_head4", fe0.pc_o, 32'h4);
    check("b_idle", 32'(fe0.mem_req_o), 32'd0);
    tick();
    check("b_reissue", 32'(fe0.mem_req_o), 32'd1);
    check("b_addr", fe0.mem_addr_o, 32'h10);
    tick();
    check("b_refull", 32'(count0), 32'd4);
    check("b_off2", 32'(fe0.mem_req_o), 32'd0);

    // C: branch during a slow request, stale response dropped
    do_reset();
    lat = 5;
    n = 0;
    while (!(fe0.mem_req_o && fe0.mem_addr_o == 32'h10) && n < 100) begin
      tick();
      n++;
    end
    check("c_reach", 32'(n < 100), 32'd1);
    check("c_cnt_pre", 32'(count0), 32'd1);
    branch = 1'b1;
    pc_in = 32'h100;
    tick();
    branch = 1'b0;
    check("c_cleared", 32'(count0), 32'd0);
    check("c_valid", 32'(fe0.valid_o), 32'd0);
    check("c_kill_req", 32'(fe0.mem_req_o), 32'd1);
    check("c_kill_addr", fe0.mem_addr_o, 32'h10);
    check("c_dbg", dbg_pc0, 32'h100);
    n = 0;
    while (!fe0.mem_valid_i && n < 20) begin
      tick();
      n++;
    end
    check("c_kill_wait", 32'(n), 32'd4);
    check("c_kill_addr2", fe0.mem_addr_o, 32'h10);
    tick();
    check("c_drop_cnt", 32'(count0), 32'd0);
    check("c_drop_req", 32'(fe0.mem_req_o), 32'd0);
    tick();
    check("c_new_req", 32'(fe0.mem_req_o), 32'd1);
    check("c_new_addr", fe0.mem_addr_o, 32'h100);
    n = 0;
    while (!fe0.valid_o && n < 20) begin
      tick();
      n++;
    end
    check("c_first_pc", fe0.pc_o, 32'h100);
    check("c_first_instr", fe0.instr_o, 32'hC0DE0100);

    // D: static prediction on the response at 0x8
    do_reset();
    bp_on = 1'b1;
    bp_match = 32'h8;
    bp_target = 32'h40;
    repeat (3) tick();
    check("d_addr8", fe0.mem_addr_o, 32'h8);
    check("d_bp_pc", bp_pc0, 32'h8);
    check("d_bp_instr", bp_instr0, 32'hC0DE0008);
    tick();
    check("d_head8", fe0.pc_o, 32'h8);
    check("d_pred1", 32'(fe0.br_pred_o), 32'd1);
    check("d_tgt_addr", fe0.mem_addr_o, 32'h40);
    check("d_dbg", dbg_pc0, 32'h40);
    check("d_nobp_addr", fe1.mem_addr_o, 32'hC);
    check("d_nobp_head", fe1.pc_o, 32'h8);
    check("d_nobp_pred", 32'(fe1.br_pred_o), 32'd0);
    tick();
    check("d_head40", fe0.pc_o, 32'h40);
    check("d_pred0", 32'(fe0.br_pred_o), 32'd0);
    check("d_instr40", fe0.instr_o, 32'hC0DE0040);
    check("d_nobp_head2", fe1.pc_o, 32'hC);

    // E: halt raised while a request is pending
    do_reset();
    lat = 3;
    tick();
    check("e_req", 32'(fe0.mem_req_o), 32'd1);
    halt = 1'b1;
    n = 0;
    while (!fe0.mem_valid_i && n < 20) begin
      check("e_dbg_hold", dbg_pc0, 32'h0);
      tick();
      n++;
    end
    check("e_wait", 32'(n), 32'd3);
    tick();
    check("e_enq", 32'(count0), 32'd1);
    check("e_enq_pc", fe0.pc_o, 32'h0);
    check("e_req_off", 32'(fe0.mem_req_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("e_halted", 32'(fe0.mem_req_o), 32'd0);
      check("e_dbg4", dbg_pc0, 32'h4);
    end
    check("e_drained", 32'(count0), 32'd0);
    halt = 1'b0;
    tick();
    check("e_resume", 32'(fe0.mem_req_o), 32'd1);
    check("e_resume_addr", fe0.mem_addr_o, 32'h4);
    #2 rstn = 1'b0;
    #1;
    check("e_async_req", 32'(fe0.mem_req_o), 32'd0);
    check("e_async_addr", fe0.mem_addr_o, 32'h0);

    // F: flush with ack and response in the same cycle
    do_reset();
    ack = 1'b0;
    repeat (3) tick();
    check("f_cnt2", 32'(count0), 32'd2);
    check("f_resp", 32'(fe0.mem_valid_i), 32'd1);
    flush = 1'b1;
    pc_in = 32'h200;
    ack = 1'b1;
    tick();
    flush = 1'b0;
    check("f_cnt0", 32'(count0), 32'd0);
    check("f_valid0", 32'(fe0.valid_o), 32'd0);
    check("f_idle", 32'(fe0.mem_req_o), 32'd0);
    check("f_dbg", dbg_pc0, 32'h200);
    check("f_addr_idle", fe0.mem_addr_o, 32'h200);
    tick();
    check("f_req", 32'(fe0.mem_req_o), 32'd1);
    check("f_req_addr", fe0.mem_addr_o, 32'h200);
    tick();
    check("f_valid", 32'(fe0.valid_o), 32'd1);
    check("f_head", fe0.pc_o, 32'h200);
    check("f_instr", fe0.instr_o, 32'hC0DE0200);
    check("f_cnt1", 32'(count0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
